// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - digit-serial adder, one 4-bit prefix slice per clock
//
// Adds two W-bit operands (W = 4*NIBBLES) plus a carry-in, one nibble per
// cycle, least significant nibble first, through a single 4-bit
// parallel-prefix slice.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   in_valid  operand request          in_ready  accepting operands (IDLE)
//   a, b      W-bit operands           cin       carry-in
//   out_valid result presented (DONE)  out_ready consumer takes result
//   sum       (a+b+cin) mod 2^W        cout      carry out of bit W-1
//   ovf       signed overflow          busy      state is not IDLE
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_sr;
    logic [W-1:0]    b_sr;
    logic            carry;
    logic [W-1:0]    sum_r;
    logic            cout_r;
    logic            ovf_r;

    // Slice signals
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       g10, p10, g32, p32, g30, p30;
    logic       c4;
    logic [3:0] slice_sum;
    logic [W+3:0] sum_cat;

    // 4-bit prefix tree: pair groups first, then the full 4-bit group, so the
    // carry-out sees two combining levels instead of a four-stage ripple.
    always_comb begin
        g   = a_sr[3:0] & b_sr[3:0];
        p   = a_sr[3:0] ^ b_sr[3:0];
        g10 = g[1] | (p[1] & g[0]);
        p10 = p[1] & p[0];
        g32 = g[3] | (p[3] & g[2]);
        p32 = p[3] & p[2];
        g30 = g32 | (p32 & g10);
        p30 = p32 & p10;
        c[0] = carry;
        c[1] = g[0] | (p[0] & carry);
        c[2] = g10 | (p10 & carry);
        c[3] = g[2] | (p[2] & c[2]);
        c4   = g30 | (p30 & carry);
        slice_sum = p ^ c;
        // New digit enters at the top; after NIBBLES shifts the low digit
        // computed first has reached bit 0. Works for NIBBLES == 1 as well.
        sum_cat = {slice_sum, sum_r};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r <= sum_cat[W+3:4];
                    a_sr  <= a_sr >> 4;
                    b_sr  <= b_sr >> 4;
                    carry <= c4;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(NIBBLES - 1)) begin
                        cout_r <= c4;
                        ovf_r  <= c[3] ^ c4;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule
